c1_bus_responder: RTL
=====================

// Module: c1_bus_responder
// PURPOSE
// Responder end of the CPU-side C1 bus: the slave that answers the two-phase read/write/invalidate
// transactions the CPU model issues. Samples command, split address and write beats, forwards one
// parallel request to a backing store (cache core or flat memory model), then turns the shared
// bus around and drives C1_RESPONSE with 0..2 read data beats. Sits between the CPU and the cache core.
// PARAMETERS
// HI_W      15  width of address phase 1 (tag+set bits)
// OFF_W     4   width of address phase 2 (byte offset in line)
// DATA_W    16  C1 data bus width; READ32/WRITE32 use two beats
// PORTS
// clk         in     1              system clock, all state on posedge
// reset_n     in     1              async active-low reset
// addr_cpu    in     HI_W           CPU address bus (hi bits phase 1, offset phase 2)
// data_cpu    inout  DATA_W         shared data bus; driven only in RESP states
// cmd_cpu     inout  3              shared command bus; driven only in RESP states
// req_valid   out    1              request to backing store, held until req_ack
// req_op      out    3              captured C1 command (READ8/16/32, INVALIDATE, WRITE8/16/32)
// req_addr    out    HI_W+OFF_W     {hi, offset}
// req_wdata   out    2*DATA_W       {beat1, beat0}; upper bits zero for WRITE8/16
// req_ack     in     1              backing store done; rdata valid in same cycle
// req_rdata   in     2*DATA_W       read result, low beat in [DATA_W-1:0]
// busy        out    1              high in every state except IDLE
// BEHAVIOUR
// Codes: NOP=0 READ8=1 READ16=2 READ32=3 INVALIDATE=4 WRITE8=5 WRITE16=6 WRITE32=7, RESPONSE=7
//   (RESPONSE and WRITE32 share 7; direction decides).
// Reset (async, any state): state=IDLE, cmd_cpu/data_cpu = Z, req_valid=0, req_op=0, req_addr=0,
//   req_wdata=0, busy=0. Pending req_ack after reset is ignored.
// FSM, one transition per posedge:
//  IDLE:  cmd_cpu!=NOP sampled -> capture op, hi=addr_cpu; go ADDR2. NOP -> stay.
//  ADDR2: capture offset=addr_cpu[OFF_W-1:0]; writes capture beat0=data_cpu.
//         WRITE32 -> WDATA1; others -> TURN.
//  WDATA1: capture beat1=data_cpu -> TURN.
//  TURN:  one idle cycle, bus not driven (CPU release); assert req_valid -> WAIT.
//  WAIT:  hold req_valid/op/addr/wdata stable; on req_ack: latch req_rdata, drop req_valid -> RESP0.
//  RESP0: drive cmd_cpu=RESPONSE, data_cpu = READ8: {8'b0, rdata[7:0]}; READ16/READ32: rdata low beat;
//         writes/INVALIDATE: data_cpu stays Z. READ32 -> RESP1; else -> IDLE.
//  RESP1: drive RESPONSE, data_cpu = rdata high beat -> IDLE.
// Bus released (Z) on entry to IDLE. Min latency, CPU cmd edge to first RESPONSE cycle with 0-wait
//   ack: 4 cycles (READ*/INVALIDATE/WRITE8/16), 5 (WRITE32).
// req_ack outside WAIT is ignored. Commands seen while busy are ignored (CPU holds cmd during the
//   transaction); the IDLE following RESP sees the NOP the CPU restores.
// Never drive cmd_cpu/data_cpu in IDLE..WAIT: no bus contention with CPU.
// WRITE8 uses beat0[7:0], WRITE16 beat0. Address offset wraps nothing: req_addr = {hi, offset} verbatim.
// TESTING
// 1 READ8 @0x00123, store ack after 0 wait, rdata=0x0000_00A5 -> one RESPONSE cycle, data_cpu=0x00A5.
// 2 READ32 @0x1F00, rdata=0xDEAD_BEEF -> RESPONSE 2 cycles: 0xBEEF then 0xDEAD, then Z, busy=0.
// 3 WRITE32 @0x2040 beats 0x1111,0x2222 -> req_op=7, req_wdata=0x2222_1111, 1 RESPONSE, data Z.
// 4 WRITE8 data 0xAB55, ack delayed 50 cycles -> req_wdata=0x0000_0055 stable 50 cycles, then RESPONSE.
// 5 reset_n low during WAIT -> outputs to reset values same cycle; late req_ack ignored; next READ16 ok.
// 6 back-to-back READ16/WRITE16/INVALIDATE -> each gets exactly one RESPONSE; no X on shared buses.

Source files
------------

// File: rtl/c1_bus_responder.sv
// Responder (slave) end of the CPU-side C1 bus. It captures a two-phase command and forwards it
// to a backing store as one parallel request, then drives the RESPONSE beats on the shared bus.
module c1_bus_responder #(
  parameter int HI_W   = 15,
  parameter int OFF_W  = 4,
  parameter int DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [HI_W-1:0]         addr_cpu,
  inout  wire  [DATA_W-1:0]       data_cpu,
  inout  wire  [2:0]              cmd_cpu,
  output logic                    req_valid,
  output logic [2:0]              req_op,
  output logic [HI_W+OFF_W-1:0]   req_addr,
  output logic [2*DATA_W-1:0]     req_wdata,
  input  logic                    req_ack,
  input  logic [2*DATA_W-1:0]     req_rdata,
  output logic                    busy
);

  // state  | meaning
  // IDLE   | waiting for a non-NOP command
  // ADDR2  | capture offset, and beat0 for writes
  // WDATA1 | capture beat1 (WRITE32 only)
  // TURN   | bus turnaround, nobody drives
  // WAIT   | request to backing store pending
  // RESP0  | first RESPONSE cycle
  // RESP1  | second RESPONSE cycle (READ32 only)
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR2, S_WDATA1, S_TURN, S_WAIT, S_RESP0, S_RESP1
  } state_t;

  localparam logic [2:0] C_NOP      = 3'd0;
  localparam logic [2:0] C_READ8    = 3'd1;
  localparam logic [2:0] C_READ16   = 3'd2;
  localparam logic [2:0] C_READ32   = 3'd3;
  localparam logic [2:0] C_WRITE8   = 3'd5;
  localparam logic [2:0] C_WRITE16  = 3'd6;
  localparam logic [2:0] C_WRITE32  = 3'd7;
  localparam logic [2:0] C_RESPONSE = 3'd7;

  state_t              state, state_nxt;
  logic [2*DATA_W-1:0] rdata_q;
  logic                cmd_oe, data_oe;
  logic [DATA_W-1:0]   data_out;
  logic                is_read;

  assign is_read  = (req_op == C_READ8) || (req_op == C_READ16) || (req_op == C_READ32);
  assign cmd_cpu  = cmd_oe  ? C_RESPONSE : 3'bz;
  assign data_cpu = data_oe ? data_out   : {DATA_W{1'bz}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (cmd_cpu != C_NOP) state_nxt = S_ADDR2;
      S_ADDR2:  state_nxt = (req_op == C_WRITE32) ? S_WDATA1 : S_TURN;
      S_WDATA1: state_nxt = S_TURN;
      S_TURN:   state_nxt = S_WAIT;
      S_WAIT:   if (req_ack) state_nxt = S_RESP0;
      S_RESP0:  state_nxt = (req_op == C_READ32) ? S_RESP1 : S_IDLE;
      S_RESP1:  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Bus drive depends on state only, so the bus is released the cycle IDLE is entered.
  always_comb begin
    busy     = (state != S_IDLE);
    cmd_oe   = 1'b0;
    data_oe  = 1'b0;
    data_out = '0;
    case (state)
      S_RESP0: begin
        cmd_oe  = 1'b1;
        data_oe = is_read;
        if (req_op == C_READ8) data_out = {{(DATA_W-8){1'b0}}, rdata_q[7:0]};
        else                   data_out = rdata_q[DATA_W-1:0];
      end
      S_RESP1: begin
        cmd_oe   = 1'b1;
        data_oe  = 1'b1;
        data_out = rdata_q[2*DATA_W-1:DATA_W];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_valid <= 1'b0;
      req_op    <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        S_IDLE: if (cmd_cpu != C_NOP) begin
          req_op                         <= cmd_cpu;
          req_addr[HI_W+OFF_W-1:OFF_W]   <= addr_cpu;
        end
        S_ADDR2: begin
          req_addr[OFF_W-1:0] <= addr_cpu[OFF_W-1:0];
          case (req_op)
            C_WRITE8:             req_wdata <= {{(2*DATA_W-8){1'b0}}, data_cpu[7:0]};
            C_WRITE16, C_WRITE32: req_wdata <= {{DATA_W{1'b0}}, data_cpu};
            default:              req_wdata <= '0;
          endcase
        end
        S_WDATA1: req_wdata[2*DATA_W-1:DATA_W] <= data_cpu;
        S_TURN:   req_valid <= 1'b1;
        S_WAIT: if (req_ack) begin
          rdata_q   <= req_rdata;
          req_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
